alu_input_mux: RTL and testbench
================================

Name: alu_input_mux

Overview:
- Combinational operand selector for the 6502 core's ALU operand input.
- Picks one of A, X, Y, data bus, stack pointer, or the constants 0/1 under a 3-bit code driven by the control unit.
- Provides a zero-latency output for the ALU datapath.
- Also provides a one-cycle registered copy plus a reserved-code error flag for the control/debug path.

Parameters:
- WIDTH, 8, datapath width of every operand and of the output.

Ports:
- clk  in  1  system clock; only the registered outputs use it.
- rst  in  1  synchronous, active-high reset.
- mux_code  in  3  operand select code.
- a_reg  in  WIDTH  accumulator.
- x_reg  in  WIDTH  X index register.
- y_reg  in  WIDTH  Y index register.
- data_in  in  WIDTH  data bus input.
- sp  in  WIDTH  stack pointer.
- out  out  WIDTH  selected operand, combinational.
- out_q  out  WIDTH  out registered on clk.
- code_err  out  1  registered flag: the previous cycle's mux_code was reserved.

Behaviour:
- Select codes (decoded on mux_code[2:0]):
  - 0 NONE -> 0
  - 1 A -> a_reg
  - 2 X -> x_reg
  - 3 Y -> y_reg
  - 4 DATA -> data_in
  - 5 SP -> sp
  - 6 ONE -> constant 1, zero-extended to WIDTH
  - 7 reserved -> 0
- out: purely combinational, zero latency.
  - Must settle within the same delta/time step as any input or mux_code change.
  - No latches; full case with a default of 0.
  - Independent of clk and rst; valid even while rst is high.
- out_q, on each rising clk edge:
  - rst=1 -> out_q <= 0
  - otherwise out_q <= the current combinational out
  - Latency exactly 1 cycle.
- code_err, on each rising clk edge:
  - rst=1 -> 0
  - otherwise <= (mux_code == 7)
  - Stays high for every consecutive cycle code 7 is held; clears one edge after a legal code is presented.
- Reset values: out_q = 0, code_err = 0. out has no reset value; it follows its inputs.
- Reset asserted mid-operation: registered outputs clear on the next edge; out is unaffected.
- Input changes between edges: only the value present at the edge is captured by out_q and code_err.
- X/Z on mux_code: out is driven to 0 via the default branch (simulation behaviour).

Decomposition:
- Shared package alu_pkg holds:
  - the 3-bit select code constants: ALU_IN_MUX_NONE=0, _A=1, _X=2, _Y=3, _DATA=4, _SP=5, _ONE=6, _RSVD=7
  - the code width constant (3)
- The control unit imports the same package.
- No sub-module: one combinational case block plus one clocked process.

Test Plan:
- Static inputs a=1, x=2, y=3, data=4, sp=5; step mux_code 0,1,2,3,4,5,6 every 10 ns -> out = 0,1,2,3,4,5,1, each in the same time step as the code change.
- mux_code=7 held 3 cycles -> out=0 throughout; code_err=1 after the first edge, 1 for all 3 cycles; back to code 1 -> code_err=0 after the next edge.
- Clocked sequence of codes 1,2,3 -> out_q = 1,2,3, each one cycle after the code was presented.
- rst high for 2 cycles with code=5 -> out_q=0 and code_err=0 while rst is high, out=5 throughout; after release, out_q=5 on the first edge.
- With code=2, change x_reg 2->0xAB mid-cycle -> out=0xAB immediately; out_q=0xAB at the next edge.
- With code=4 and data_in=0xFF -> out=0xFF. With code=6 -> out=0x01 regardless of the other inputs at 0xFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared select-code definitions for the ALU operand input mux.
// The control unit imports this same package so both sides agree on the encoding.
package alu_pkg;

  localparam int ALU_IN_MUX_CODE_W = 3;

  localparam logic [ALU_IN_MUX_CODE_W-1:0] ALU_IN_MUX_NONE = 3'd0;
  localparam logic [ALU_IN_MUX_CODE_W-1:0] ALU_IN_MUX_A    = 3'd1;
  localparam logic [ALU_IN_MUX_CODE_W-1:0] ALU_IN_MUX_X    = 3'd2;
  localparam logic [ALU_IN_MUX_CODE_W-1:0] ALU_IN_MUX_Y    = 3'd3;
  localparam logic [ALU_IN_MUX_CODE_W-1:0] ALU_IN_MUX_DATA = 3'd4;
  localparam logic [ALU_IN_MUX_CODE_W-1:0] ALU_IN_MUX_SP   = 3'd5;
  localparam logic [ALU_IN_MUX_CODE_W-1:0] ALU_IN_MUX_ONE  = 3'd6;
  localparam logic [ALU_IN_MUX_CODE_W-1:0] ALU_IN_MUX_RSVD = 3'd7;

endpackage

// File: rtl/alu_input_mux.sv
// Operand selector feeding the 6502 ALU: zero-latency output for the datapath,
// plus a registered copy and reserved-code flag for the control/debug path.
module alu_input_mux
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ALU_IN_MUX_CODE_W-1:0] mux_code,
  input  logic [WIDTH-1:0]             a_reg,
  input  logic [WIDTH-1:0]             x_reg,
  input  logic [WIDTH-1:0]             y_reg,
  input  logic [WIDTH-1:0]             data_in,
  input  logic [WIDTH-1:0]             sp,
  output logic [WIDTH-1:0]             out,
  output logic [WIDTH-1:0]             out_q,
  output logic                         code_err
);

  // Reserved and unknown codes fall through to zero so the ALU never sees stale data.
  always_comb begin
    out = '0;
    case (mux_code)
      ALU_IN_MUX_NONE: out = '0;
      ALU_IN_MUX_A:    out = a_reg;
      ALU_IN_MUX_X:    out = x_reg;
      ALU_IN_MUX_Y:    out = y_reg;
      ALU_IN_MUX_DATA: out = data_in;
      ALU_IN_MUX_SP:   out = sp;
      ALU_IN_MUX_ONE:  out = WIDTH'(1);
      default:         out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      code_err <= 1'b0;
    end else begin
      out_q    <= out;
      code_err <= (mux_code == ALU_IN_MUX_RSVD);
    end
  end

endmodule

// File: tb/tb_alu_input_mux.sv
// Self-checking bench for alu_input_mux: combinational output checked right after
// each drive, registered outputs checked through an expected-value queue.
module tb_alu_input_mux;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [2:0]       mux_code;
  logic [WIDTH-1:0] a_reg, x_reg, y_reg, data_in, sp;
  logic [WIDTH-1:0] out, out_q;
  logic             code_err;

  int total_count;
  int bad_count;

  // Each entry holds {code_err, out_q} expected after the next rising edge.
  logic [WIDTH:0] exp_queue[$];

  alu_input_mux #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .mux_code (mux_code),
    .a_reg    (a_reg),
    .x_reg    (x_reg),
    .y_reg    (y_reg),
    .data_in  (data_in),
    .sp       (sp),
    .out      (out),
    .out_q    (out_q),
    .code_err (code_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] modelOut();
    logic [WIDTH-1:0] r;
    r = '0;
    if (mux_code == 3'd1)      r = a_reg;
    else if (mux_code == 3'd2) r = x_reg;
    else if (mux_code == 3'd3) r = y_reg;
    else if (mux_code == 3'd4) r = data_in;
    else if (mux_code == 3'd5) r = sp;
    else if (mux_code == 3'd6) r = 8'h01;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_count++;
    if (observed !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive on the falling edge and check the combinational path in the same step.
  task automatic applyStimulus(input logic [2:0] code, input logic r);
    @(negedge clk);
    mux_code = code;
    rst      = r;
    #1;
    checkOutput($sformatf("out code=%0d", code), 32'(out), 32'(modelOut()));
  endtask

  task automatic clockAndCheck(input string tag);
    logic [WIDTH:0] e;
    exp_queue.push_back(rst ? '0 : {(mux_code == 3'd7), modelOut()});
    @(posedge clk);
    #1;
    if (exp_queue.size() == 0) begin
      checkOutput({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_queue.pop_front();
      checkOutput({tag, " out_q"}, 32'(out_q), 32'(e[WIDTH-1:0]));
      checkOutput({tag, " code_err"}, 32'(code_err), 32'(e[WIDTH]));
    end
  endtask

  initial begin
    total_count = 0;
    bad_count   = 0;
    rst      = 1'b1;
    mux_code = 3'd0;
    a_reg = 8'd1; x_reg = 8'd2; y_reg = 8'd3; data_in = 8'd4; sp = 8'd5;

    // Reset state
    applyStimulus(3'd0, 1'b1);
    clockAndCheck("reset0");
    applyStimulus(3'd7, 1'b1);
    clockAndCheck("reset1");

    // Walk legal codes with distinct static operands
    for (int c = 0; c < 7; c++) begin
      applyStimulus(3'(c), 1'b0);
      clockAndCheck($sformatf("walk%0d", c));
    end

    // Reserved code held three cycles, then back to a legal code
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'd7, 1'b0);
      checkOutput("rsvd out zero", 32'(out), 32'd0);
      clockAndCheck($sformatf("rsvd%0d", i));
    end
    applyStimulus(3'd1, 1'b0);
    clockAndCheck("rsvd_clear");

    // Back-to-back codes 1,2,3
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(3'(c), 1'b0);
      clockAndCheck($sformatf("seq%0d", c));
    end

    // Reset mid-operation with code 5 held
    for (int i = 0; i < 2; i++) begin
      applyStimulus(3'd5, 1'b1);
      checkOutput("rst out passthru", 32'(out), 32'd5);
      clockAndCheck($sformatf("midrst%0d", i));
    end
    applyStimulus(3'd5, 1'b0);
    clockAndCheck("rst_release");

    // Mid-cycle operand change: only the value at the edge is captured
    applyStimulus(3'd2, 1'b0);
    #2;
    x_reg = 8'hAB;
    #1;
    checkOutput("x change out", 32'(out), 32'hAB);
    clockAndCheck("x_change");

    // All operands at 0xFF
    a_reg = 8'hFF; x_reg = 8'hFF; y_reg = 8'hFF; data_in = 8'hFF; sp = 8'hFF;
    applyStimulus(3'd4, 1'b0);
    checkOutput("data ff", 32'(out), 32'hFF);
    clockAndCheck("data_ff");
    applyStimulus(3'd6, 1'b0);
    checkOutput("one ignores ff", 32'(out), 32'h01);
    clockAndCheck("one_ff");
    applyStimulus(3'd0, 1'b0);
    checkOutput("none ignores ff", 32'(out), 32'h00);
    clockAndCheck("none_ff");

    // Random sweep
    for (int i = 0; i < 40; i++) begin
      a_reg   = 8'($urandom);
      x_reg   = 8'($urandom);
      y_reg   = 8'($urandom);
      data_in = 8'($urandom);
      sp      = 8'($urandom);
      applyStimulus(3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
      clockAndCheck($sformatf("rand%0d", i));
    end

    checkOutput("queue drained", 32'(exp_queue.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
